mriscv_trace_collector: RTL

Parametrised multi-port execution-trace collector for MPSoC-RISCV cores. It accepts up to NR_PORTS retired-instruction trace records per cycle and filters them by mode. Records are timestamped and buffered in a multi-write FIFO. The block serialises them onto one valid/ready stream toward the debug-interconnect packetiser. Unlike the single-record trace struct, it handles configurable XLEN, multiple retire ports, filtering, buffering, overflow accounting and in-band overflow markers.

---
 rtl/mriscv_trace_pkg.sv | 26 ++
 rtl/mriscv_trace_fifo.sv | 52 +++++
 rtl/mriscv_trace_collector.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mriscv_trace_pkg.sv
// Shared constants and helpers for the MPSoC-RISCV execution-trace collector.
package mriscv_trace_pkg;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_ALL = 2'b01;
  localparam logic [1:0] MODE_CF  = 2'b10;
  localparam logic [1:0] MODE_WB  = 2'b11;

  localparam logic KIND_EXEC = 1'b0;
  localparam logic KIND_OVFL = 1'b1;

  typedef enum logic [0:0] {
    ST_NORM = 1'b0,
    ST_OVFL = 1'b1
  } coll_state_e;

  // Port index width that stays legal for a single retire port.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mriscv_trace_fifo.sv
// Multi-write, single-read first-word-fall-through FIFO for trace entries.
module mriscv_trace_fifo
  import mriscv_trace_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEPTH     = 16,
  parameter int NR_PORTS  = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NR_PORTS*W-1:0] wr_data,
  input  logic [AW:0]           wr_cnt,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic [AW:0]           occupancy
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   occ_r;
  logic          rd_s;

  assign rd_s = rd_en & (occ_r != {(AW+1){1'b0}});

  // Storage: lanes 0..wr_cnt-1 land in consecutive slots starting at wptr.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_PORTS; i++) begin
      if ((AW+1)'(i) < wr_cnt) begin
        mem_r[wptr_r + AW'(i)] <= wr_data[i*W +: W];
      end
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_r <= {AW{1'b0}};
      rptr_r <= {AW{1'b0}};
      occ_r  <= {(AW+1){1'b0}};
    end else begin
      wptr_r <= wptr_r + wr_cnt[AW-1:0];
      rptr_r <= rptr_r + AW'(rd_s);
      occ_r  <= occ_r + wr_cnt - (AW+1)'(rd_s);
    end
  end

  assign rd_data   = mem_r[rptr_r];
  assign occupancy = occ_r;

endmodule

// File: rtl/mriscv_trace_collector.sv
// Multi-port retired-instruction trace collector: filter, timestamp, buffer,
// account overflows and serialise onto one valid/ready stream.
module mriscv_trace_collector
  import mriscv_trace_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NR_PORTS = 2,
  parameter int DEPTH    = 16,
  parameter int TSW      = 16,
  parameter int CNTW     = 16,
  localparam int IW      = idx_width(NR_PORTS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [1:0]               cfg_mode,
  input  logic [NR_PORTS-1:0]      trace_valid,
  input  logic [NR_PORTS*32-1:0]   trace_insn,
  input  logic [NR_PORTS*XLEN-1:0] trace_pc,
  input  logic [NR_PORTS-1:0]      trace_jb,
  input  logic [NR_PORTS-1:0]      trace_jal,
  input  logic [NR_PORTS-1:0]      trace_jr,
  input  logic [NR_PORTS*XLEN-1:0] trace_jbtarget,
  input  logic [NR_PORTS*XLEN-1:0] trace_wbdata,
  input  logic [NR_PORTS*5-1:0]    trace_wbreg,
  input  logic [NR_PORTS-1:0]      trace_wben,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_kind,
  output logic [TSW-1:0]           out_ts,
  output logic [IW-1:0]            out_port,
  output logic [31:0]              out_insn,
  output logic [XLEN-1:0]          out_pc,
  output logic [2:0]               out_flags,
  output logic [XLEN-1:0]          out_jbtarget,
  output logic [XLEN-1:0]          out_wbdata,
  output logic [4:0]               out_wbreg,
  output logic                     out_wben,
  output logic [CNTW-1:0]          out_drops,
  output logic                     stat_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 1 + TSW + IW + 32 + 3 * XLEN + 3 + 5 + 1;
  localparam int SW = CNTW + AW + 1;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [AW:0]     ZERO_N  = {(AW+1){1'b0}};

  logic [TSW-1:0]        ts_r;
  logic [CNTW-1:0]       cnt_r;
  coll_state_e           state_r;
  logic                  stat_r;

  logic [NR_PORTS-1:0]   pass_s;
  logic [AW:0]           occ_s;
  logic [AW:0]           free_s;
  logic [AW:0]           npass_s;
  logic [AW:0]           nwr_s;
  logic [AW:0]           ndrop_s;
  logic [AW:0]           wr_cnt_s;
  logic [AW:0]           pos_s;
  logic [SW-1:0]         cnt_sum_s;
  logic [CNTW-1:0]       cnt_sat_s;
  logic                  marker_s;
  logic                  match_s;
  logic [NR_PORTS*W-1:0] lanes_s;
  logic [NR_PORTS*W-1:0] wr_data_s;
  logic [W-1:0]          marker_vec_s;
  logic [W-1:0]          head_s;
  logic                  rd_en_s;

  logic                  h_kind_s;
  logic [TSW-1:0]        h_ts_s;
  logic [IW-1:0]         h_port_s;
  logic [31:0]           h_insn_s;
  logic [XLEN-1:0]       h_pc_s;
  logic [XLEN-1:0]       h_jbt_s;
  logic [XLEN-1:0]       h_wbd_s;
  logic [2:0]            h_flags_s;
  logic [4:0]            h_wbreg_s;
  logic                  h_wben_s;

  // Per-port mode filter.
  always_comb begin
    pass_s  = {NR_PORTS{1'b0}};
    match_s = 1'b0;
    for (int i = 0; i < NR_PORTS; i++) begin
      case (cfg_mode)
        MODE_ALL: match_s = 1'b1;
        MODE_CF:  match_s = trace_jb[i] | trace_jal[i] | trace_jr[i];
        MODE_WB:  match_s = trace_wben[i];
        default:  match_s = 1'b0;
      endcase
      pass_s[i] = trace_valid[i] & match_s;
    end
  end

  // Write/drop split against the space left by the registered occupancy.
  always_comb begin
    npass_s = ZERO_N;
    for (int i = 0; i < NR_PORTS; i++) begin
      npass_s = npass_s + (AW+1)'(pass_s[i]);
    end
    free_s = (AW+1)'(DEPTH) - occ_s;
    if (state_r == ST_NORM) begin
      if (npass_s > free_s) begin
        nwr_s   = free_s;
        ndrop_s = npass_s - free_s;
      end else begin
        nwr_s   = npass_s;
        ndrop_s = ZERO_N;
      end
    end else begin
      nwr_s   = ZERO_N;
      ndrop_s = npass_s;
    end
    cnt_sum_s = SW'(cnt_r) + SW'(ndrop_s);
    if (cnt_sum_s > SW'(CNT_MAX)) begin
      cnt_sat_s = CNT_MAX;
    end else begin
      cnt_sat_s = cnt_sum_s[CNTW-1:0];
    end
    marker_s = (state_r == ST_OVFL) && (free_s != ZERO_N);
  end

  // Compact passing records into lanes; pos never exceeds the port index.
  always_comb begin
    lanes_s = {(NR_PORTS*W){1'b0}};
    pos_s   = ZERO_N;
    for (int i = 0; i < NR_PORTS; i++) begin
      lanes_s[int'(pos_s)*W +: W] = lanes_s[int'(pos_s)*W +: W] |
        ({W{pass_s[i] && (pos_s < nwr_s)}} &
         {KIND_EXEC, ts_r, IW'(i), trace_insn[32*i +: 32],
          trace_pc[XLEN*i +: XLEN], trace_jbtarget[XLEN*i +: XLEN],
          trace_wbdata[XLEN*i +: XLEN], trace_jb[i], trace_jal[i], trace_jr[i],
          trace_wbreg[5*i +: 5], trace_wben[i]});
      pos_s = pos_s + (AW+1)'(pass_s[i]);
    end
  end

  // Marker entries carry the drop count in the wbdata field.
  always_comb begin
    marker_vec_s = {KIND_OVFL, ts_r, {IW{1'b0}}, 32'h0000_0000, {XLEN{1'b0}},
                    {XLEN{1'b0}}, XLEN'(cnt_sat_s), 3'b000, 5'b00000, 1'b0};
    wr_data_s    = {(NR_PORTS*W){1'b0}};
    if (marker_s) begin
      wr_data_s[W-1:0] = marker_vec_s;
      wr_cnt_s         = (AW+1)'(1);
    end else begin
      wr_data_s = lanes_s;
      wr_cnt_s  = nwr_s;
    end
  end

  // Timestamp, saturating drop counter and overflow state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_r    <= {TSW{1'b0}};
      cnt_r   <= {CNTW{1'b0}};
      state_r <= ST_NORM;
      stat_r  <= 1'b0;
    end else begin
      ts_r <= ts_r + TSW'(1);
      case (state_r)
        ST_NORM: begin
          if (ndrop_s != ZERO_N) begin
            state_r <= ST_OVFL;
            stat_r  <= 1'b1;
            cnt_r   <= cnt_sat_s;
          end else begin
            state_r <= ST_NORM;
            stat_r  <= 1'b0;
          end
        end
        ST_OVFL: begin
          if (marker_s) begin
            state_r <= ST_NORM;
            stat_r  <= 1'b0;
            cnt_r   <= {CNTW{1'b0}};
          end else begin
            state_r <= ST_OVFL;
            stat_r  <= 1'b1;
            cnt_r   <= cnt_sat_s;
          end
        end
        default: begin
          state_r <= ST_NORM;
          stat_r  <= 1'b0;
          cnt_r   <= {CNTW{1'b0}};
        end
      endcase
    end
  end

  mriscv_trace_fifo #(
    .W        (W),
    .DEPTH    (DEPTH),
    .NR_PORTS (NR_PORTS)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .wr_data   (wr_data_s),
    .wr_cnt    (wr_cnt_s),
    .rd_en     (rd_en_s),
    .rd_data   (head_s),
    .occupancy (occ_s)
  );

  assign out_valid     = (occ_s != ZERO_N);
  assign rd_en_s       = out_valid & out_ready;
  assign stat_overflow = stat_r;
  assign {h_kind_s, h_ts_s, h_port_s, h_insn_s, h_pc_s, h_jbt_s, h_wbd_s,
          h_flags_s, h_wbreg_s, h_wben_s} = head_s;

  // Present the FIFO head; everything reads zero while nothing is buffered.
  always_comb begin
    if (out_valid) begin
      out_kind     = h_kind_s;
      out_ts       = h_ts_s;
      out_port     = h_port_s;
      out_insn     = h_insn_s;
      out_pc       = h_pc_s;
      out_flags    = h_flags_s;
      out_jbtarget = h_jbt_s;
      out_wbreg    = h_wbreg_s;
      out_wben     = h_wben_s;
      if (h_kind_s == KIND_OVFL) begin
        out_wbdata = {XLEN{1'b0}};
        out_drops  = h_wbd_s[CNTW-1:0];
      end else begin
        out_wbdata = h_wbd_s;
        out_drops  = {CNTW{1'b0}};
      end
    end else begin
      out_kind     = 1'b0;
      out_ts       = {TSW{1'b0}};
      out_port     = {IW{1'b0}};
      out_insn     = 32'h0000_0000;
      out_pc       = {XLEN{1'b0}};
      out_flags    = 3'b000;
      out_jbtarget = {XLEN{1'b0}};
      out_wbreg    = 5'b00000;
      out_wben     = 1'b0;
      out_wbdata   = {XLEN{1'b0}};
      out_drops    = {CNTW{1'b0}};
    end
  end

endmodule
